// File: rtl/ledio_pkg.sv
// ledio shared constants: register offsets, CTRL field layout and reset values.
package ledio_pkg;

   // Register offsets within the LED window
   localparam logic [2:0] LEDIO_ADDR_LO   = 3'b000;
   localparam logic [2:0] LEDIO_ADDR_HI   = 3'b010;
   localparam logic [2:0] LEDIO_ADDR_CTRL = 3'b100;

   // Bus and LED image widths
   localparam int unsigned LEDIO_DATA_W = 16;
   localparam int unsigned LEDIO_LED_W  = 24;
   localparam int unsigned LEDIO_HI_W   = 8;

   // CTRL field positions; duty occupies [LSB +: PWM_W]
   localparam int unsigned LEDIO_CTRL_DUTY_LSB  = 0;
   localparam int unsigned LEDIO_CTRL_DUTY_MSB  = 7;
   localparam int unsigned LEDIO_CTRL_BLINK_BIT = 8;

   // Reset duty is all-ones (full brightness); truncated to PWM_W at use
   localparam logic [LEDIO_DATA_W-1:0] LEDIO_DUTY_RST = 16'hFFFF;

endpackage

// File: rtl/ledio_pwm.sv
// ledio brightness PWM and blink timer. Blink logic exists only when
// LEDIO_BLINK_EN is defined; otherwise blank_c is constant 0.
module ledio_pwm
   import ledio_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 24,
   parameter int unsigned PWM_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PWM_W-1:0] duty,
   input  logic             blink_en,
   output logic             pwm_on_c,
   output logic             blank_c
);

   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

   // Free-running PWM counter and duty compare; all-ones duty forces on
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      pwm_on_c  = (duty == {PWM_W{1'b1}}) || (pwm_cnt_q < duty);
   end

   // PWM counter register, updates on the falling edge
   always_ff @(negedge clk or posedge rst) begin
      if (rst) pwm_cnt_q <= '0;
      else     pwm_cnt_q <= pwm_cnt_d;
   end

`ifdef LEDIO_BLINK_EN
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic                  phase_q, phase_d;

   // Prescaler counts every cycle; phase toggles on wrap to zero
   always_comb begin
      pre_d   = pre_q + PRESCALE_W'(1);
      phase_d = (pre_d == '0) ? ~phase_q : phase_q;
      blank_c = blink_en & phase_q;
   end

   // Blink timer registers
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         pre_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         phase_q <= phase_d;
      end
   end
`else
   localparam int unsigned UNUSED_PRESCALE_W = PRESCALE_W;
   logic unused_blink_en;

   // No blink timer in this build
   assign unused_blink_en = blink_en;
   assign blank_c         = 1'b0;
`endif

endmodule

// File: rtl/ledio.sv
// ledio: memory-mapped 24-bit LED port with readback, PWM brightness and
// optional blink (enabled by defining LEDIO_BLINK_EN).
module ledio
   import ledio_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 24,
   parameter int unsigned PWM_W      = 8
) (
   input  logic                    ledclk,
   input  logic                    ledrst,
   input  logic                    ledcs,
   input  logic                    ledwrite,
   input  logic                    ledread,
   input  logic [2:0]              ledaddr,
   input  logic [LEDIO_DATA_W-1:0] ledwdata,
   output logic [LEDIO_DATA_W-1:0] ledrdata,
   output logic [LEDIO_LED_W-1:0]  led_o
);

   logic [LEDIO_LED_W-1:0]  led_q, led_d;
   logic [PWM_W-1:0]        duty_q, duty_d;
   logic [LEDIO_DATA_W-1:0] rdata_q, rdata_d;
   logic [LEDIO_DATA_W-1:0] rd_mux, ctrl_rd;
   logic [LEDIO_LED_W-1:0]  led_o_q, led_o_d;
   logic                    blink_en;
   logic                    wr_en, rd_en;
   logic                    pwm_on, blank;

`ifdef LEDIO_BLINK_EN
   logic blink_en_q, blink_en_d;
   assign blink_en = blink_en_q;
`else
   assign blink_en = 1'b0;
`endif

   assign wr_en = ledcs & ledwrite;
   assign rd_en = ledcs & ledread;

   // Brightness and blink generation
   ledio_pwm #(
      .PRESCALE_W (PRESCALE_W),
      .PWM_W      (PWM_W)
   ) u_pwm (
      .clk      (ledclk),
      .rst      (ledrst),
      .duty     (duty_q),
      .blink_en (blink_en),
      .pwm_on_c (pwm_on),
      .blank_c  (blank)
   );

   // Readback mux; pre-write register values so read+write returns old data
   always_comb begin
      ctrl_rd = '0;
      ctrl_rd[LEDIO_CTRL_DUTY_LSB +: PWM_W] = duty_q;
      ctrl_rd[LEDIO_CTRL_BLINK_BIT]         = blink_en;
      case (ledaddr)
         LEDIO_ADDR_LO:   rd_mux = led_q[LEDIO_DATA_W-1:0];
         LEDIO_ADDR_HI:   rd_mux = {{(LEDIO_DATA_W-LEDIO_HI_W){1'b0}}, led_q[LEDIO_LED_W-1:LEDIO_DATA_W]};
         LEDIO_ADDR_CTRL: rd_mux = ctrl_rd;
         default:         rd_mux = '0;
      endcase
   end

   // Register writes, readback capture and gated LED output
   always_comb begin
      led_d   = led_q;
      duty_d  = duty_q;
`ifdef LEDIO_BLINK_EN
      blink_en_d = blink_en_q;
`endif
      if (wr_en) begin
         case (ledaddr)
            LEDIO_ADDR_LO:   led_d[LEDIO_DATA_W-1:0] = ledwdata;
            LEDIO_ADDR_HI:   led_d[LEDIO_LED_W-1:LEDIO_DATA_W] = ledwdata[LEDIO_HI_W-1:0];
            LEDIO_ADDR_CTRL: begin
               duty_d = ledwdata[LEDIO_CTRL_DUTY_LSB +: PWM_W];
`ifdef LEDIO_BLINK_EN
               blink_en_d = ledwdata[LEDIO_CTRL_BLINK_BIT];
`endif
            end
            default: ;
         endcase
      end
      rdata_d = rd_en ? rd_mux : rdata_q;
      led_o_d = led_q & {LEDIO_LED_W{pwm_on & ~blank}};
   end

   // State registers, falling-edge clocked with asynchronous reset
   always_ff @(negedge ledclk or posedge ledrst) begin
      if (ledrst) begin
         led_q   <= '0;
         duty_q  <= PWM_W'(LEDIO_DUTY_RST);
         rdata_q <= '0;
         led_o_q <= '0;
`ifdef LEDIO_BLINK_EN
         blink_en_q <= 1'b0;
`endif
      end else begin
         led_q   <= led_d;
         duty_q  <= duty_d;
         rdata_q <= rdata_d;
         led_o_q <= led_o_d;
`ifdef LEDIO_BLINK_EN
         blink_en_q <= blink_en_d;
`endif
      end
   end

   assign ledrdata = rdata_q;
   assign led_o    = led_o_q;

endmodule

// File: tb/tb_ledio.sv
// Directed scoreboard bench for ledio (PRESCALE_W = 4, PWM_W = 8).
module tb_ledio;
   import ledio_pkg::*;

   logic        ledclk, ledrst, ledcs, ledwrite, ledread;
   logic [2:0]  ledaddr;
   logic [15:0] ledwdata, ledrdata;
   logic [23:0] led_o;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] exp_q[$];

   ledio #(.PRESCALE_W(4), .PWM_W(8)) dut (
      .ledclk   (ledclk),
      .ledrst   (ledrst),
      .ledcs    (ledcs),
      .ledwrite (ledwrite),
      .ledread  (ledread),
      .ledaddr  (ledaddr),
      .ledwdata (ledwdata),
      .ledrdata (ledrdata),
      .led_o    (led_o)
   );

   initial ledclk = 1'b1;
   always #5 ledclk = ~ledclk;

   task automatic push(input logic [23:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [23:0] obs);
      logic [23:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %h, no expected value queued", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   // Advance past one falling edge and settle
   task automatic cycle();
      @(negedge ledclk);
      #1;
   endtask

   task automatic wr(input logic cs, input logic [2:0] a, input logic [15:0] d);
      ledcs = cs; ledwrite = 1'b1; ledaddr = a; ledwdata = d;
      cycle();
      ledcs = 1'b0; ledwrite = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
      push({8'h00, exp});
      ledcs = 1'b1; ledread = 1'b1; ledaddr = a;
      cycle();
      ledcs = 1'b0; ledread = 1'b0;
      check(tag, {8'h00, ledrdata});
   endtask

   initial begin
      int  on_cnt, bad, t, waited;
      logic on_s[64];
      logic exp_on;

      ledrst = 1'b1; ledcs = 1'b0; ledwrite = 1'b0; ledread = 1'b0;
      ledaddr = 3'b000; ledwdata = 16'h0000;
      #1;
      push(24'h0); check("reset_led_o", led_o);
      push(24'h0); check("reset_rdata", {8'h00, ledrdata});
      #6 ledrst = 1'b0;

      rd("reset_ctrl", LEDIO_ADDR_CTRL, 16'h00FF);

      // LO then HI write, one-edge output latency
      wr(1'b1, LEDIO_ADDR_LO, 16'hA5C3);
      wr(1'b1, LEDIO_ADDR_HI, 16'h12F0);
      push(24'h00A5C3); check("led_o_before_hi", led_o);
      cycle();
      push(24'hF0A5C3); check("led_o_after_hi", led_o);
      rd("hi_readback", LEDIO_ADDR_HI, 16'h00F0);
      rd("lo_readback", LEDIO_ADDR_LO, 16'hA5C3);

      // Unselected and unmapped writes are ignored
      wr(1'b0, LEDIO_ADDR_LO, 16'h0000);
      wr(1'b0, LEDIO_ADDR_HI, 16'h0000);
      wr(1'b1, 3'b110, 16'hFFFF);
      rd("lo_after_nocs", LEDIO_ADDR_LO, 16'hA5C3);
      rd("hi_after_nocs", LEDIO_ADDR_HI, 16'h00F0);
      rd("unmapped_read", 3'b110, 16'h0000);
      push(24'hF0A5C3); check("led_o_unchanged", led_o);

      // Simultaneous read and write returns the old value
      wr(1'b1, LEDIO_ADDR_LO, 16'h1111);
      push(24'h001111);
      ledcs = 1'b1; ledwrite = 1'b1; ledread = 1'b1;
      ledaddr = LEDIO_ADDR_LO; ledwdata = 16'h2222;
      cycle();
      ledcs = 1'b0; ledwrite = 1'b0; ledread = 1'b0;
      check("rw_same_cycle_old", {8'h00, ledrdata});
      rd("rw_next_read_new", LEDIO_ADDR_LO, 16'h2222);

      // PWM at duty 0x40: 64 of 256 cycles on
      wr(1'b1, LEDIO_ADDR_LO, 16'hFFFF);
      wr(1'b1, LEDIO_ADDR_CTRL, 16'h0040);
      rd("ctrl_duty40", LEDIO_ADDR_CTRL, 16'h0040);
      cycle(); cycle();
      on_cnt = 0; bad = 0;
      for (int i = 0; i < 256; i++) begin
         cycle();
         if (led_o[15:0] == 16'hFFFF) on_cnt++;
         else if (led_o[15:0] != 16'h0000) bad++;
      end
      push(24'd64); check("pwm40_on_cycles", 24'(on_cnt));
      push(24'd0);  check("pwm40_partial", 24'(bad));

      // Duty 0: always off
      wr(1'b1, LEDIO_ADDR_CTRL, 16'h0000);
      cycle(); cycle();
      on_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         cycle();
         if (led_o != 24'h0) on_cnt++;
      end
      push(24'd0); check("pwm0_on_cycles", 24'(on_cnt));

      // Full duty with blink request
      wr(1'b1, LEDIO_ADDR_CTRL, 16'h01FF);
      cycle(); cycle();
      on_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         cycle();
         on_s[i] = (led_o != 24'h0);
         if (on_s[i]) on_cnt++;
      end
`ifdef LEDIO_BLINK_EN
      rd("ctrl_blink", LEDIO_ADDR_CTRL, 16'h01FF);
      push(24'd32); check("blink_on_cycles", 24'(on_cnt));
      t = 0;
      for (int i = 1; i <= 17; i++)
         if (t == 0 && on_s[i] != on_s[i-1]) t = i;
      push(24'd1); check("blink_edge_found", 24'((t != 0) && (t <= 16)));
      bad = 0;
      for (int k = 0; k < 32; k++) begin
         exp_on = (k < 16) ? on_s[t] : !on_s[t];
         if (on_s[t+k] != exp_on) bad++;
      end
      push(24'd0); check("blink_pattern", 24'(bad));
`else
      rd("ctrl_noblink", LEDIO_ADDR_CTRL, 16'h00FF);
      push(24'd64); check("noblink_on_cycles", 24'(on_cnt));
`endif

      // Reset mid-operation clears outputs without a clock edge
      waited = 0;
      while (led_o == 24'h0 && waited < 40) begin
         cycle();
         waited++;
      end
      push(24'd1); check("pre_reset_on", 24'(led_o != 24'h0));
      #2 ledrst = 1'b1;
      #1;
      push(24'h0); check("async_reset_led_o", led_o);
      push(24'h0); check("async_reset_rdata", {8'h00, ledrdata});
      #1 ledrst = 1'b0;
      rd("post_reset_ctrl", LEDIO_ADDR_CTRL, 16'h00FF);
      rd("post_reset_lo", LEDIO_ADDR_LO, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
